// File: rtl/edid_ddc_master.sv
// DDC/I2C master that reads the EDID block from sink address DEV_ADDR into a local buffer.
// Define EDID_CHECKSUM_EN to keep a modulo-256 byte sum and report csum_ok at done.
module edid_ddc_master #(
  parameter int unsigned CLK_DIV   = 250,
  parameter int unsigned NUM_BYTES = 128,
  parameter logic [6:0]  DEV_ADDR  = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       csum_ok
);

  localparam int unsigned DivW    = $clog2(CLK_DIV);
  localparam logic [7:0]  LastIdx = 8'(NUM_BYTES - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StWaddr, StWack, StOffs, StOack,
    StRstart, StRaddr, StRack, StRdata, StMack, StStop
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [DivW-1:0] r_div_cnt;
  logic [1:0]      r_phase;
  logic [2:0]      r_bit;
  logic [6:0]      r_shift;
  logic [7:0]      r_byte_cnt;
  logic            r_last, r_nack;
  logic            r_sda_s1, r_sda_s2;
  logic            r_done, r_error, r_scl_oe, r_sda_oe, r_mem_we;
  logic [7:0]      r_mem_addr, r_mem_data;

  logic       w_tick, w_sample, w_bit_end, w_byte_end, w_accept;
  logic       w_ack_state, w_tx_state, w_byte_rx, w_stop_end;
  logic [7:0] w_tx_byte, w_rx_byte;
  logic       w_scl_oe, w_sda_oe;

  assign w_tick      = (r_state != StIdle) && (r_div_cnt == DivW'(CLK_DIV - 1));
  assign w_sample    = w_tick && (r_phase == 2'd2);
  assign w_bit_end   = w_tick && (r_phase == 2'd3);
  assign w_byte_end  = w_bit_end && (r_bit == 3'd0);
  assign w_accept    = start && (r_state == StIdle);
  assign w_ack_state = (r_state == StWack) || (r_state == StOack) || (r_state == StRack);
  assign w_tx_state  = (r_state == StWaddr) || (r_state == StOffs) || (r_state == StRaddr);
  assign w_byte_rx   = w_sample && (r_state == StRdata) && (r_bit == 3'd0);
  assign w_stop_end  = w_bit_end && (r_state == StStop);
  assign w_rx_byte   = {r_shift, r_sda_s2};

  always_comb begin
    w_tx_byte = 8'h00;
    if (r_state == StWaddr) w_tx_byte = {DEV_ADDR, 1'b0};
    if (r_state == StRaddr) w_tx_byte = {DEV_ADDR, 1'b1};
  end

  // SDA idles high, so the synchroniser resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (start)      w_state_nxt = StStart;
      StStart:  if (w_bit_end)  w_state_nxt = StWaddr;
      StWaddr:  if (w_byte_end) w_state_nxt = StWack;
      StWack:   if (w_bit_end)  w_state_nxt = r_nack ? StStop : StOffs;
      StOffs:   if (w_byte_end) w_state_nxt = StOack;
      StOack:   if (w_bit_end)  w_state_nxt = r_nack ? StStop : StRstart;
      StRstart: if (w_bit_end)  w_state_nxt = StRaddr;
      StRaddr:  if (w_byte_end) w_state_nxt = StRack;
      StRack:   if (w_bit_end)  w_state_nxt = r_nack ? StStop : StRdata;
      StRdata:  if (w_byte_end) w_state_nxt = StMack;
      StMack:   if (w_bit_end)  w_state_nxt = r_last ? StStop : StRdata;
      StStop:   if (w_bit_end)  w_state_nxt = StIdle;
      default:                  w_state_nxt = StIdle;
    endcase
  end

  // Bus levels per quarter; START/Sr pull SDA in q2 while SCL is high, STOP releases it in q2.
  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
      end
      StStart: begin
        w_scl_oe = (r_phase == 2'd3);
        w_sda_oe = r_phase[1];
      end
      StRstart: begin
        w_scl_oe = (r_phase == 2'd0) || (r_phase == 2'd3);
        w_sda_oe = r_phase[1];
      end
      StWaddr, StOffs, StRaddr: begin
        w_scl_oe = (r_phase == 2'd0) || (r_phase == 2'd3);
        w_sda_oe = ~w_tx_byte[r_bit];
      end
      StWack, StOack, StRack, StRdata: begin
        w_scl_oe = (r_phase == 2'd0) || (r_phase == 2'd3);
        w_sda_oe = 1'b0;
      end
      StMack: begin
        w_scl_oe = (r_phase == 2'd0) || (r_phase == 2'd3);
        w_sda_oe = ~r_last;
      end
      StStop: begin
        w_scl_oe = (r_phase == 2'd0);
        w_sda_oe = ~r_phase[1];
      end
      default: begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_phase    <= 2'd0;
      r_bit      <= 3'd7;
      r_shift    <= 7'h00;
      r_byte_cnt <= 8'h00;
      r_last     <= 1'b0;
      r_nack     <= 1'b0;
    end else if (r_state == StIdle) begin
      r_div_cnt <= '0;
      r_phase   <= 2'd0;
      r_bit     <= 3'd7;
      if (start) begin
        r_byte_cnt <= 8'h00;
        r_last     <= 1'b0;
        r_nack     <= 1'b0;
      end
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DivW'(1);
      if (w_tick) r_phase <= r_phase + 2'd1;
      // The 3-bit index wraps 0 -> 7 at each byte end.
      if (w_bit_end && (w_tx_state || (r_state == StRdata))) r_bit <= r_bit - 3'd1;
      if (w_sample && w_ack_state && r_sda_s2) r_nack <= 1'b1;
      if (w_sample && (r_state == StRdata)) r_shift <= {r_shift[5:0], r_sda_s2};
      if (w_byte_rx) begin
        r_last     <= (r_byte_cnt == LastIdx);
        r_byte_cnt <= r_byte_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_oe   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= 8'h00;
      r_mem_data <= 8'h00;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_scl_oe <= w_scl_oe;
      r_sda_oe <= w_sda_oe;
      r_mem_we <= w_byte_rx;
      if (w_byte_rx) begin
        r_mem_addr <= r_byte_cnt;
        r_mem_data <= w_rx_byte;
      end
      r_done <= w_stop_end && !r_nack;
      if (w_accept)                r_error <= 1'b0;
      else if (w_stop_end && r_nack) r_error <= 1'b1;
    end
  end

`ifdef EDID_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_csum_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum    <= 8'h00;
      r_csum_ok <= 1'b0;
    end else if (w_accept) begin
      r_csum    <= 8'h00;
      r_csum_ok <= 1'b0;
    end else begin
      if (w_byte_rx)               r_csum    <= r_csum + w_rx_byte;
      if (w_stop_end && !r_nack)   r_csum_ok <= (r_csum == 8'h00);
    end
  end

  assign csum_ok = r_csum_ok;
`else
  assign csum_ok = 1'b0;
`endif

  assign busy     = (r_state != StIdle);
  assign done     = r_done;
  assign error    = r_error;
  assign scl_oe   = r_scl_oe;
  assign sda_oe   = r_sda_oe;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;

endmodule

// File: tb/tb_edid_ddc_master.sv
// Bench for edid_ddc_master: two masters (128 and 1 byte) share one open-drain bus with a
// behavioural EDID sink; a scoreboard checks every buffer write and every completion.
module tb_edid_ddc_master;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned NBig   = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start_v = 2'b00;
  logic [1:0] busy_v, done_v, error_v, scl_oe_v, sda_oe_v, we_v, csum_v;
  logic [7:0] addr_v [2];
  logic [7:0] data_v [2];
  logic       slave_oe = 1'b0;
  logic       slave_present = 1'b1;
  logic       bus_scl, bus_sda;

  assign bus_scl = ~(|scl_oe_v);
  assign bus_sda = ~((|sda_oe_v) | slave_oe);

  always #5 clk = ~clk;

  edid_ddc_master #(.CLK_DIV(ClkDiv), .NUM_BYTES(NBig), .DEV_ADDR(7'h50)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .error(error_v[0]), .scl_oe(scl_oe_v[0]), .sda_oe(sda_oe_v[0]), .sda_i(bus_sda),
    .mem_we(we_v[0]), .mem_addr(addr_v[0]), .mem_data(data_v[0]), .csum_ok(csum_v[0])
  );

  edid_ddc_master #(.CLK_DIV(ClkDiv), .NUM_BYTES(1), .DEV_ADDR(7'h50)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .error(error_v[1]), .scl_oe(scl_oe_v[1]), .sda_oe(sda_oe_v[1]), .sda_i(bus_sda),
    .mem_we(we_v[1]), .mem_addr(addr_v[1]), .mem_data(data_v[1]), .csum_ok(csum_v[1])
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Sink ROM; bytes 0..127 always sum to 0 mod 256 unless deliberately corrupted.
  logic [7:0] rom [256];

  task automatic fill_rom();
    int s = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 127; i++) s += int'(rom[i]);
    rom[127] = 8'(0 - s);
  endtask

  // Behavioural DDC sink reacting to bus edges.
  typedef enum int {SIdle, SRecv, SAck, STx, SMack} sl_e;
  sl_e        sl_st = SIdle;
  logic [7:0] sl_sh = 8'h00;
  logic [7:0] sl_ptr = 8'h00;
  int         sl_cnt = 0;
  bit         sl_first = 1'b0;
  bit         sl_rd = 1'b0;
  logic       sl_mack = 1'b1;
  logic [7:0] sl_rx [$];
  int         sl_acks = 0;
  int         sl_nacks = 0;

  initial begin
    logic pscl, psda, scl, sda;
    pscl = 1'b1;
    psda = 1'b1;
    forever begin
      @(negedge clk);
      scl = bus_scl;
      sda = bus_sda;
      if (!rst_n) begin
        sl_st    = SIdle;
        slave_oe = 1'b0;
      end else if (pscl && scl && psda && !sda) begin
        sl_st = SRecv; sl_cnt = 0; sl_first = 1'b1; slave_oe = 1'b0;
      end else if (pscl && scl && !psda && sda) begin
        sl_st = SIdle; slave_oe = 1'b0;
      end else if (!pscl && scl) begin
        if (sl_st == SRecv) begin
          sl_sh = {sl_sh[6:0], sda};
          sl_cnt++;
        end else if (sl_st == SMack) begin
          sl_mack = sda;
        end
      end else if (pscl && !scl) begin
        case (sl_st)
          SRecv: if (sl_cnt == 8) begin
            sl_rx.push_back(sl_sh);
            if (sl_first && sl_sh[7:1] != 7'h50) begin
              sl_st = SIdle;
            end else begin
              if (sl_first) sl_rd = sl_sh[0];
              else          sl_ptr = sl_sh;
              sl_first = 1'b0;
              sl_st    = SAck;
              slave_oe = slave_present;
            end
          end
          SAck: if (sl_rd) begin
            sl_st = STx; sl_cnt = 1; slave_oe = slave_present & ~rom[sl_ptr][7];
          end else begin
            sl_st = SRecv; sl_cnt = 0; slave_oe = 1'b0;
          end
          STx: if (sl_cnt == 8) begin
            slave_oe = 1'b0; sl_st = SMack;
          end else begin
            slave_oe = slave_present & ~rom[sl_ptr][7-sl_cnt];
            sl_cnt++;
          end
          SMack: if (sl_mack == 1'b0) begin
            sl_acks++; sl_ptr++; sl_st = STx; sl_cnt = 1;
            slave_oe = slave_present & ~rom[sl_ptr][7];
          end else begin
            sl_nacks++; sl_st = SIdle; slave_oe = 1'b0;
          end
          default: ;
        endcase
      end
      pscl = scl;
      psda = sda;
    end
  end

  // Scoreboard queues filled at issue time.
  typedef struct {int dut; logic [7:0] addr; logic [7:0] data;} wr_t;
  typedef struct {int dut; bit ok; bit csum; int n;} cmp_t;
  wr_t  exp_wr [$];
  cmp_t exp_cmp [$];

  initial begin
    logic [1:0] perr;
    wr_t        e;
    cmp_t       c;
    logic [31:0] rxv;
    perr = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        perr = 2'b00;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (we_v[d]) begin
            if (exp_wr.size() == 0) fail("unexpected_mem_we");
            else begin
              e = exp_wr.pop_front();
              check("mem_write", {15'd0, 1'(d), addr_v[d], data_v[d]},
                    {15'd0, 1'(e.dut), e.addr, e.data});
            end
          end
          if (done_v[d] || (error_v[d] && !perr[d])) begin
            if (exp_cmp.size() == 0) fail("unexpected_completion");
            else begin
              c = exp_cmp.pop_front();
              check("completion", {28'd0, 1'(d), done_v[d], error_v[d], busy_v[d]},
                    {28'd0, 1'(c.dut), c.ok, ~c.ok, 1'b0});
              if (c.ok) begin
                check("csum_ok", {31'd0, csum_v[d]}, {31'd0, c.csum});
                check("master_ack_pattern", {16'(sl_acks), 16'(sl_nacks)},
                      {16'(c.n - 1), 16'd1});
                check("writes_outstanding", exp_wr.size(), 0);
                rxv = 32'hFFFF_FFFF;
                if (sl_rx.size() == 3) rxv = {8'h00, sl_rx[0], sl_rx[1], sl_rx[2]};
                check("bus_header", rxv, 32'h00A0_00A1);
              end else begin
                rxv = 32'hFFFF_FFFF;
                if (sl_rx.size() == 1) rxv = {24'h0, sl_rx[0]};
                check("nack_header", rxv, 32'h0000_00A0);
              end
            end
          end
          perr[d] = error_v[d];
        end
      end
    end
  end

  // Called just after a negedge; pushes the reference expectation and pulses start.
  task automatic issue(input int d, input bit present);
    int n, s;
    bit cs;
    n = (d == 0) ? int'(NBig) : 1;
    s = 0;
    slave_present = present;
    sl_rx.delete();
    sl_acks = 0;
    sl_nacks = 0;
    if (present) begin
      for (int i = 0; i < n; i++) begin
        exp_wr.push_back('{dut: d, addr: 8'(i), data: rom[i]});
        s += int'(rom[i]);
      end
    end
`ifdef EDID_CHECKSUM_EN
    cs = ((s % 256) == 0);
`else
    cs = 1'b0;
`endif
    exp_cmp.push_back('{dut: d, ok: present, csum: cs, n: n});
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    check("busy_after_start", {31'd0, busy_v[d]}, 32'd1);
    check("error_cleared", {31'd0, error_v[d]}, 32'd0);
    check("done_single_cycle", {31'd0, done_v[d]}, 32'd0);
  endtask

  task automatic wait_end(input int d);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_v[d] && !error_v[d] && k < 30000);
    if (k >= 30000) fail("timeout_waiting_for_end");
    #1;
  endtask

  task automatic wait_write(input int idx);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(we_v[0] && addr_v[0] == 8'(idx)) && k < 30000);
    if (k >= 30000) fail("timeout_waiting_for_write");
    #1;
  endtask

  initial begin
    fill_rom();
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1;  // start under reset must be ignored
    @(negedge clk);
    start_v[0] = 1'b0;
    check("reset_outputs", {18'd0, scl_oe_v, sda_oe_v, busy_v, done_v, error_v, we_v, csum_v},
          32'd0);
    check("reset_addr_data", {addr_v[0], data_v[0], addr_v[1], data_v[1]}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("start_during_reset_ignored", {30'd0, busy_v}, 32'd0);
    #1;

    // Sink absent: NACK on the address byte, STOP, sticky error.
    issue(0, 1'b0);
    wait_end(0);
    repeat (5) @(negedge clk);
    check("nack_error_sticky", {29'd0, error_v[0], busy_v[0], done_v[0]}, 32'b100);
    check("bus_released", {30'd0, scl_oe_v[0], sda_oe_v[0]}, 32'd0);
    #1;

    // Full read with a stray start mid-transfer, then a start in the done cycle.
    issue(0, 1'b1);
    wait_write(10 + int'($urandom_range(0, 5)));
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_end(0);
    check("done_pulse_read1", {31'd0, done_v[0]}, 32'd1);
    rom[127] = rom[127] + 8'd1;
    issue(0, 1'b1);
    wait_end(0);
    check("done_pulse_read2", {31'd0, done_v[0]}, 32'd1);
    rom[127] = rom[127] - 8'd1;
    repeat (3) @(negedge clk);
    #1;

    // Reset during byte 40 releases the bus at once; a clean read follows.
    issue(0, 1'b1);
    wait_write(39);
    repeat ($urandom_range(5, 100)) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_bus", {30'd0, scl_oe_v[0], sda_oe_v[0]}, 32'd0);
    check("midreset_outputs", {busy_v[0], done_v[0], error_v[0], we_v[0], csum_v[0], 3'd0,
                               addr_v[0], data_v[0], 8'd0}, 32'd0);
    exp_wr.delete();
    exp_cmp.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    issue(0, 1'b1);
    wait_end(0);
    check("done_pulse_read3", {31'd0, done_v[0]}, 32'd1);
    repeat (3) @(negedge clk);
    #1;

    // Single-byte master: one write at address 0, NACK, STOP.
    issue(1, 1'b1);
    wait_end(1);
    check("done_pulse_single", {31'd0, done_v[1]}, 32'd1);
    repeat (10) @(negedge clk);
    check("queues_drained", exp_wr.size() + exp_cmp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
